// File: rtl/pd_pkg.sv
// Shared state encoding, output bundle and default timing for the power-domain sequencer.
package pd_pkg;

  typedef enum logic [3:0] {
    ST_ON,
    ST_ISO,
    ST_SAVE,
    ST_PSW_OFF,
    ST_OFF,
    ST_PSW_ON,
    ST_SETTLE,
    ST_RESTORE,
    ST_DEISO,
    ST_FAULT
  } pd_state_t;

  localparam int unsigned ISO_SETUP_DEF   = 2;
  localparam int unsigned SAVE_CYC_DEF    = 1;
  localparam int unsigned SETTLE_CYC_DEF  = 4;
  localparam int unsigned RESTORE_CYC_DEF = 1;
  localparam int unsigned PWR_TIMEOUT_DEF = 64;
  localparam int unsigned CNT_W_DEF       = 7;

  typedef struct packed {
    logic iso_n;
    logic ret_save;
    logic ret_restore;
    logic pwr_en;
    logic pd_ack;
    logic dom_on;
    logic err_timeout;
  } pd_out_t;

  // Isolation is only released in DEISO/ON, both of which keep the switch closed.
  function automatic pd_out_t decode_out(input pd_state_t s);
    pd_out_t o;
    o = '{iso_n: 1'b0, ret_save: 1'b0, ret_restore: 1'b0, pwr_en: 1'b1,
          pd_ack: 1'b0, dom_on: 1'b0, err_timeout: 1'b0};
    case (s)
      ST_ON:      begin o.iso_n = 1'b1; o.dom_on = 1'b1; end
      ST_SAVE:    o.ret_save = 1'b1;
      ST_PSW_OFF: o.pwr_en = 1'b0;
      ST_OFF:     begin o.pwr_en = 1'b0; o.pd_ack = 1'b1; end
      ST_RESTORE: o.ret_restore = 1'b1;
      ST_DEISO:   o.iso_n = 1'b1;
      ST_FAULT:   begin o.pwr_en = 1'b0; o.err_timeout = 1'b1; end
      default:    ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pd_iso_seq_if.sv
// Handshake and cell-control bundle between the system controller and the sequencer.
interface pd_iso_seq_if;
  logic pd_req;
  logic pd_ack;
  logic pwr_ok;
  logic err_clr;
  logic iso_n;
  logic ret_save;
  logic ret_restore;
  logic pwr_en;
  logic dom_on;
  logic err_timeout;

  modport master (
    output pd_req, pwr_ok, err_clr,
    input  pd_ack, iso_n, ret_save, ret_restore, pwr_en, dom_on, err_timeout
  );

  modport slave (
    input  pd_req, pwr_ok, err_clr,
    output pd_ack, iso_n, ret_save, ret_restore, pwr_en, dom_on, err_timeout
  );
endinterface

// File: rtl/pd_dly_cnt.sv
// Up-counter with synchronous clear and a terminal-value compare, used for every hold/timeout wait.
module pd_dly_cnt #(
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             hit
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign hit = (cnt_reg == term);

endmodule

// File: rtl/pd_iso_seq.sv
// Power-domain sequencer: orders isolation, retention save/restore and the power switch.
module pd_iso_seq
  import pd_pkg::*;
#(
  parameter int unsigned ISO_SETUP   = ISO_SETUP_DEF,
  parameter int unsigned SAVE_CYC    = SAVE_CYC_DEF,
  parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int unsigned RESTORE_CYC = RESTORE_CYC_DEF,
  parameter int unsigned PWR_TIMEOUT = PWR_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input logic         clk,
  input logic         rst_n,
  pd_iso_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] T_ISO     = CNT_W'(ISO_SETUP - 1);
  localparam logic [CNT_W-1:0] T_SAVE    = CNT_W'(SAVE_CYC - 1);
  localparam logic [CNT_W-1:0] T_SETTLE  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] T_RESTORE = CNT_W'(RESTORE_CYC - 1);
  localparam logic [CNT_W-1:0] T_PWR     = CNT_W'(PWR_TIMEOUT - 1);

  pd_state_t        state_reg, state_next;
  logic             saved_reg, saved_next;
  pd_out_t          out_reg, out_next;
  logic [CNT_W-1:0] term;
  logic             hit;
  logic             cnt_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_PSW_ON;
      saved_reg <= 1'b0;
      out_reg   <= decode_out(ST_PSW_ON);
    end else begin
      state_reg <= state_next;
      saved_reg <= saved_next;
      out_reg   <= out_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    saved_next = saved_reg;
    term       = T_PWR;
    case (state_reg)
      ST_ON:      if (bus.pd_req) state_next = ST_ISO;
      ST_ISO: begin
        term = T_ISO;
        if (hit) state_next = ST_SAVE;
      end
      ST_SAVE: begin
        term = T_SAVE;
        if (hit) begin
          state_next = ST_PSW_OFF;
          saved_next = 1'b1;
        end
      end
      // A met exit condition wins over a timeout landing on the same cycle.
      ST_PSW_OFF: begin
        if (!bus.pwr_ok) state_next = ST_OFF;
        else if (hit)    state_next = ST_FAULT;
      end
      ST_OFF:     if (!bus.pd_req) state_next = ST_PSW_ON;
      ST_PSW_ON: begin
        if (bus.pwr_ok) state_next = ST_SETTLE;
        else if (hit)   state_next = ST_FAULT;
      end
      ST_SETTLE: begin
        term = T_SETTLE;
        if (hit) state_next = saved_reg ? ST_RESTORE : ST_DEISO;
      end
      ST_RESTORE: begin
        term = T_RESTORE;
        if (hit) begin
          state_next = ST_DEISO;
          saved_next = 1'b0;
        end
      end
      ST_DEISO:   state_next = ST_ON;
      ST_FAULT:   if (bus.err_clr) state_next = ST_PSW_ON;
      default:    state_next = ST_PSW_ON;
    endcase
    cnt_clr  = (state_next != state_reg);
    out_next = decode_out(state_next);
  end

  pd_dly_cnt #(.CNT_W(CNT_W)) u_dly_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (1'b1),
    .term (term),
    .hit  (hit)
  );

  assign bus.iso_n       = out_reg.iso_n;
  assign bus.ret_save    = out_reg.ret_save;
  assign bus.ret_restore = out_reg.ret_restore;
  assign bus.pwr_en      = out_reg.pwr_en;
  assign bus.pd_ack      = out_reg.pd_ack;
  assign bus.dom_on      = out_reg.dom_on;
  assign bus.err_timeout = out_reg.err_timeout;

endmodule

// File: tb/tb_pd_iso_seq.sv
// Directed bench for pd_iso_seq: reset power-up, power-down/up, timeout, mid-sequence events, random invariants.
module tb_pd_iso_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  pd_iso_seq_if bus();

  pd_iso_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Power-up with no saved state: PSW_ON 1 cycle, SETTLE 4 cycles, DEISO, ON.
  task automatic up_no_restore(input string tag);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check({tag, "_iso_n"}, bus.iso_n, i >= 5);
      check({tag, "_dom_on"}, bus.dom_on, i >= 6);
      check({tag, "_no_restore"}, bus.ret_restore, 1'b0);
    end
  endtask

  // Called right after PSW_ON is entered with pwr_ok=1 and saved state pending.
  task automatic up_restore(input string tag);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check({tag, "_restore"}, bus.ret_restore, i == 5);
      check({tag, "_iso_n"}, bus.iso_n, i >= 6);
      check({tag, "_dom_on"}, bus.dom_on, i == 7);
      check({tag, "_pd_ack"}, bus.pd_ack, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("inv_iso_implies_pwr", bus.iso_n & ~bus.pwr_en, 1'b0);
      check("inv_save_restore", bus.ret_save & bus.ret_restore, 1'b0);
    end
  end

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    bus.pd_req  = 1'b0;
    bus.pwr_ok  = 1'b1;
    bus.err_clr = 1'b0;
    repeat (3) tick();
    check("rst_iso_n", bus.iso_n, 1'b0);
    check("rst_pwr_en", bus.pwr_en, 1'b1);
    check("rst_ret_save", bus.ret_save, 1'b0);
    check("rst_ret_restore", bus.ret_restore, 1'b0);
    check("rst_pd_ack", bus.pd_ack, 1'b0);
    check("rst_dom_on", bus.dom_on, 1'b0);
    check("rst_err_timeout", bus.err_timeout, 1'b0);

    rst_n = 1'b1;
    up_no_restore("boot");

    // Power-down.
    bus.pd_req = 1'b1;
    tick();
    check("dn_iso_fall", bus.iso_n, 1'b0);
    check("dn_dom_off", bus.dom_on, 1'b0);
    tick();
    check("dn_save_early", bus.ret_save, 1'b0);
    tick();
    check("dn_save", bus.ret_save, 1'b1);
    check("dn_save_pwr", bus.pwr_en, 1'b1);
    tick();
    check("dn_save_end", bus.ret_save, 1'b0);
    check("dn_pwr_off", bus.pwr_en, 1'b0);
    repeat (3) begin
      tick();
      check("dn_ack_early", bus.pd_ack, 1'b0);
    end
    bus.pwr_ok = 1'b0;
    tick();
    check("dn_ack", bus.pd_ack, 1'b1);
    check("dn_off_iso", bus.iso_n, 1'b0);
    check("dn_off_pwr", bus.pwr_en, 1'b0);

    // Power-up with restore.
    bus.pd_req = 1'b0;
    tick();
    check("up_ack_drop", bus.pd_ack, 1'b0);
    check("up_pwr_on", bus.pwr_en, 1'b1);
    check("up_iso_held", bus.iso_n, 1'b0);
    repeat (9) begin
      tick();
      check("up_wait_iso", bus.iso_n, 1'b0);
    end
    bus.pwr_ok = 1'b1;
    up_restore("up");

    // Timeout in PSW_OFF.
    bus.pd_req = 1'b1;
    repeat (4) tick();
    check("to_pwr_off", bus.pwr_en, 1'b0);
    repeat (63) tick();
    check("to_not_yet", bus.err_timeout, 1'b0);
    tick();
    check("to_fault", bus.err_timeout, 1'b1);
    check("to_fault_iso", bus.iso_n, 1'b0);
    check("to_fault_pwr", bus.pwr_en, 1'b0);
    check("to_fault_ack", bus.pd_ack, 1'b0);
    bus.pd_req = 1'b0;
    tick();
    check("to_fault_hold", bus.err_timeout, 1'b1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("to_clr", bus.err_timeout, 1'b0);
    check("to_clr_pwr", bus.pwr_en, 1'b1);
    up_restore("to_up");

    // pd_req dropped during SAVE.
    bus.pd_req = 1'b1;
    repeat (3) tick();
    check("mid_save", bus.ret_save, 1'b1);
    bus.pd_req = 1'b0;
    tick();
    check("mid_pwr_off", bus.pwr_en, 1'b0);
    bus.pwr_ok = 1'b0;
    tick();
    check("mid_ack", bus.pd_ack, 1'b1);
    tick();
    check("mid_ack_drop", bus.pd_ack, 1'b0);
    check("mid_pwr_on", bus.pwr_en, 1'b1);
    bus.pwr_ok = 1'b1;
    up_restore("mid_up");

    // Reset asserted during SAVE.
    bus.pd_req = 1'b1;
    repeat (3) tick();
    check("rs_save", bus.ret_save, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rs_save_clr", bus.ret_save, 1'b0);
    check("rs_iso_n", bus.iso_n, 1'b0);
    check("rs_pwr_en", bus.pwr_en, 1'b1);
    check("rs_pd_ack", bus.pd_ack, 1'b0);
    bus.pd_req = 1'b0;
    tick();
    rst_n = 1'b1;
    up_no_restore("rs_up");

    // Random traffic; invariants are checked by the negedge monitor.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) bus.pd_req = ~bus.pd_req;
      if ($urandom_range(0, 5) == 0) bus.pwr_ok = ~bus.pwr_ok;
      bus.err_clr = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
